vga_sincronismo: RTL and testbench
==================================

# vga_sincronismo

Raster timing generator for the 640x480@60 Hz VGA output. It divides the system clock down to a pixel tick and runs horizontal and vertical counters. It drives `hsync`/`vsync` to the connector and `coluna`, `linha` and `areaAtiva` to the per-vessel drawing stages (submarine, cruiser, etc.) and the grid overlay. Every drawing stage samples its pixel coordinates from this block.

## Interface
- `DIVISOR`, 2: system clocks per pixel (50 MHz -> 25 MHz); legal values 1..16
- `H_VISIVEL`, 640; `H_FRENTE`, 16; `H_SINC`, 96; `H_TRAS`, 48: horizontal widths in pixels
- `V_VISIVEL`, 480; `V_FRENTE`, 10; `V_SINC`, 2; `V_TRAS`, 33: vertical widths in lines
- `SINC_POL`, 0: level of `hsync`/`vsync` during the sync pulse (0 = active-low)

Ports:
- `clk`  in  1  system clock; the block's only clock
- `rst`  in  1  reset; synchronous, active-high
- `pixelTick`  out  1  high on the clk in which the pixel position advances
- `coluna`  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800)
- `linha`  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- `areaAtiva`  out  1  high while coluna < H_VISIVEL and linha < V_VISIVEL
- `hsync`  out  1  horizontal sync to the connector
- `vsync`  out  1  vertical sync to the connector
- `fimQuadro`  out  1  one-clk pulse when the position wraps to (0,0)

## Operation
- Divider:
  - `divCnt` is 4 bits and counts 0..DIVISOR-1, then wraps.
  - `pixelTick` = (divCnt == DIVISOR-1), decoded from the register.
  - With DIVISOR=1, `pixelTick` is constantly 1, including during reset.
- Horizontal counter `coluna`:
  - On a clk with pixelTick=1 it increments.
  - At H_TOTAL-1 it wraps to 0 instead.
- Vertical counter `linha`:
  - Increments only on a pixelTick where `coluna` wraps.
  - At V_TOTAL-1 it wraps to 0.
- `coluna` and `linha` are the counter registers themselves, with raw values and no blanking to 0. Consumers gate with `areaAtiva`.
- `hsync` = SINC_POL while H_VISIVEL+H_FRENTE <= coluna < H_VISIVEL+H_FRENTE+H_SINC (656..751), else ~SINC_POL.
- `vsync` = SINC_POL while V_VISIVEL+V_FRENTE <= linha < V_VISIVEL+V_FRENTE+V_SINC (490..491), else ~SINC_POL.
  - The transition is aligned to coluna = 0 of the line.
- `hsync`, `vsync`, `areaAtiva` and `fimQuadro` are registers computed from the next counter values. They are therefore always consistent with `coluna`/`linha` in the same clk, with no skew.
- `fimQuadro` goes high for exactly one clk: the clk in which the counters first show (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - It is not asserted on leaving reset.
- Counter arithmetic is 10-bit unsigned. Totals are derived from the parameters, and a total > 1024 is a configuration error, flagged by a simulation-only check.

## Timing
- Reset values: divCnt=0, coluna=0, linha=0, areaAtiva=1, hsync=~SINC_POL, vsync=~SINC_POL, fimQuadro=0. `pixelTick` follows divCnt.
- Reset mid-frame takes effect on the next clk edge. The block then restarts at (0,0), divCnt=0, with no `fimQuadro` pulse.
- First advance after reset release: the DIVISOR-th clk (coluna 0 -> 1).
- Each position is held for exactly DIVISOR clks.
- Line period: 800·DIVISOR clks. Frame period: 420000·DIVISOR clks.
- A downstream stage sampling on `pixelTick` sees each position exactly once.

## Test plan
- Reset, DIVISOR=2: hold `rst` for 3 clks, release.
  - During reset: coluna=0, linha=0, areaAtiva=1, hsync=1, vsync=1, fimQuadro=0.
  - After release, coluna becomes 1 on the 2nd clk.
- Horizontal sync: run one line.
  - hsync falls when coluna=656 and stays low for 192 clks (96 pixels).
  - areaAtiva falls at coluna=640.
  - coluna wraps 799 -> 0 and linha increments 0 -> 1 on the same clk.
- Vertical sync: run to linha=490.
  - vsync falls with coluna=0, linha=490 and rises at coluna=0, linha=492 (3200 clks low).
  - areaAtiva is 0 for all of linha 480..524.
- Frame wrap: run 2 frames.
  - fimQuadro pulses 1 clk, exactly 840000 clks apart, each time coincident with coluna=0, linha=0.
  - No pulse after reset release.
- Mid-frame reset: assert `rst` at coluna=300, linha=200.
  - Next clk: all outputs at reset values.
  - After release, timing restarts identically to the first scenario.
- DIVISOR=1 build: pixelTick constantly 1, coluna advances every clk, line period 800 clks, hsync low 96 clks.

Source files
------------

// File: rtl/vga_sincronismo.sv
// Raster timing generator for 640x480@60 Hz VGA.
// Divides the system clock to a pixel tick, runs the column/line counters and
// produces registered sync, active-area and end-of-frame flags that are always
// aligned with the counter values visible in the same clock.
module vga_sincronismo #(
  parameter int   DIVISOR   = 2,
  parameter int   H_VISIVEL = 640,
  parameter int   H_FRENTE  = 16,
  parameter int   H_SINC    = 96,
  parameter int   H_TRAS    = 48,
  parameter int   V_VISIVEL = 480,
  parameter int   V_FRENTE  = 10,
  parameter int   V_SINC    = 2,
  parameter int   V_TRAS    = 33,
  parameter logic SINC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixelTick,
  output logic [9:0] coluna,
  output logic [9:0] linha,
  output logic       areaAtiva,
  output logic       hsync,
  output logic       vsync,
  output logic       fimQuadro
);

  localparam int H_TOTAL = H_VISIVEL + H_FRENTE + H_SINC + H_TRAS;
  localparam int V_TOTAL = V_VISIVEL + V_FRENTE + V_SINC + V_TRAS;

  localparam logic [3:0] DIV_MAX = 4'(DIVISOR - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIVEL);
  localparam logic [9:0] V_VIS   = 10'(V_VISIVEL);
  localparam logic [9:0] HS_INI  = 10'(H_VISIVEL + H_FRENTE);
  localparam logic [9:0] HS_FIM  = 10'(H_VISIVEL + H_FRENTE + H_SINC);
  localparam logic [9:0] VS_INI  = 10'(V_VISIVEL + V_FRENTE);
  localparam logic [9:0] VS_FIM  = 10'(V_VISIVEL + V_FRENTE + V_SINC);

  // Configuration errors are reported while the design is elaborated for simulation.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_total
    $error("vga_sincronismo: H_TOTAL or V_TOTAL exceeds 1024");
  end
  if (DIVISOR < 1 || DIVISOR > 16) begin : g_cfg_div
    $error("vga_sincronismo: DIVISOR must be 1..16");
  end

  logic [3:0] div_cnt;
  logic [9:0] coluna_n;
  logic [9:0] linha_n;
  logic       col_fim;
  logic       lin_fim;

  // Pixel tick is decoded straight from the divider register; with DIVISOR=1
  // the register never leaves 0, so the tick is permanently high.
  assign pixelTick = (div_cnt == DIV_MAX);

  // Next counter values; flags below are computed from these so they line up
  // with the counters in the same clock.
  always_comb begin
    coluna_n = coluna;
    linha_n  = linha;
    col_fim  = (coluna == H_MAX);
    lin_fim  = (linha == V_MAX);
    if (pixelTick) begin
      if (col_fim) begin
        coluna_n = 10'd0;
        linha_n  = lin_fim ? 10'd0 : linha + 10'd1;
      end else begin
        coluna_n = coluna + 10'd1;
      end
    end
  end

  // Divider, counters and registered timing flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= 4'd0;
      coluna    <= 10'd0;
      linha     <= 10'd0;
      areaAtiva <= 1'b1;
      hsync     <= ~SINC_POL;
      vsync     <= ~SINC_POL;
      fimQuadro <= 1'b0;
    end else begin
      div_cnt   <= pixelTick ? 4'd0 : div_cnt + 4'd1;
      coluna    <= coluna_n;
      linha     <= linha_n;
      areaAtiva <= (coluna_n < H_VIS) && (linha_n < V_VIS);
      hsync     <= ((coluna_n >= HS_INI) && (coluna_n < HS_FIM)) ? SINC_POL : ~SINC_POL;
      vsync     <= ((linha_n >= VS_INI) && (linha_n < VS_FIM)) ? SINC_POL : ~SINC_POL;
      fimQuadro <= pixelTick && col_fim && lin_fim;
    end
  end

endmodule

// File: tb/tb_vga_sincronismo.sv
// Bench for vga_sincronismo: full-size instances at DIVISOR=2 and DIVISOR=1,
// plus a reduced-geometry instance (24x10 raster) for frame-level timing.
module tb_vga_sincronismo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Full-size, DIVISOR=2
  logic       pt_a, aa_a, hs_a, vs_a, fim_a;
  logic [9:0] col_a, lin_a;
  // Full-size, DIVISOR=1
  logic       pt_1, aa_1, hs_1, vs_1, fim_1;
  logic [9:0] col_1, lin_1;
  // Small raster: H 16/2/4/2 = 24, V 6/1/2/1 = 10, DIVISOR=2 -> 480 clks per frame
  logic       pt_s, aa_s, hs_s, vs_s, fim_s;
  logic [9:0] col_s, lin_s;

  vga_sincronismo #(.DIVISOR(2)) dut_a (
    .clk(clk), .rst(rst), .pixelTick(pt_a), .coluna(col_a), .linha(lin_a),
    .areaAtiva(aa_a), .hsync(hs_a), .vsync(vs_a), .fimQuadro(fim_a)
  );

  vga_sincronismo #(.DIVISOR(1)) dut_1 (
    .clk(clk), .rst(rst), .pixelTick(pt_1), .coluna(col_1), .linha(lin_1),
    .areaAtiva(aa_1), .hsync(hs_1), .vsync(vs_1), .fimQuadro(fim_1)
  );

  vga_sincronismo #(
    .DIVISOR(2),
    .H_VISIVEL(16), .H_FRENTE(2), .H_SINC(4), .H_TRAS(2),
    .V_VISIVEL(6),  .V_FRENTE(1), .V_SINC(2), .V_TRAS(1)
  ) dut_s (
    .clk(clk), .rst(rst), .pixelTick(pt_s), .coluna(col_s), .linha(lin_s),
    .areaAtiva(aa_s), .hsync(hs_s), .vsync(vs_s), .fimQuadro(fim_s)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Outputs are sampled and rst is driven on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " a coluna"}, 32'(col_a), 0);
    check({tag, " a linha"},  32'(lin_a), 0);
    check({tag, " a area"},   32'(aa_a),  1);
    check({tag, " a hsync"},  32'(hs_a),  1);
    check({tag, " a vsync"},  32'(vs_a),  1);
    check({tag, " a fim"},    32'(fim_a), 0);
    check({tag, " a tick"},   32'(pt_a),  0);
  endtask

  task automatic check_reset_s(input string tag);
    check({tag, " s coluna"}, 32'(col_s), 0);
    check({tag, " s linha"},  32'(lin_s), 0);
    check({tag, " s area"},   32'(aa_s),  1);
    check({tag, " s hsync"},  32'(hs_s),  1);
    check({tag, " s vsync"},  32'(vs_s),  1);
    check({tag, " s fim"},    32'(fim_s), 0);
    check({tag, " s tick"},   32'(pt_s),  0);
  endtask

  // Called right after rst is released: runs the small raster for 1000 clks,
  // i.e. just over two frames.
  task automatic small_run(input string tag);
    int   vs_fall_c, vs_rise_c, vs_fall_col, vs_fall_lin, vs_rise_col, vs_rise_lin;
    int   fim_pos_bad, aa_bad;
    logic prev_vs;
    vs_fall_c = -1; vs_rise_c = -1;
    vs_fall_col = -1; vs_fall_lin = -1; vs_rise_col = -1; vs_rise_lin = -1;
    fim_pos_bad = 0; aa_bad = 0;
    prev_vs = vs_s;
    exp_q.delete();
    exp_q.push_back(32'd480);
    exp_q.push_back(32'd960);
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c == 1) check({tag, " coluna clk1"}, 32'(col_s), 0);
      if (c == 2) check({tag, " coluna clk2"}, 32'(col_s), 1);
      if (fim_s) begin
        if (exp_q.size() > 0) check({tag, " fim clk"}, 32'(c), exp_q.pop_front());
        else check({tag, " fim unexpected clk"}, 32'(c), 0);
        if (col_s != 10'd0 || lin_s != 10'd0) fim_pos_bad++;
      end
      if (prev_vs && !vs_s && vs_fall_c < 0) begin
        vs_fall_c = c; vs_fall_col = int'(col_s); vs_fall_lin = int'(lin_s);
      end
      if (!prev_vs && vs_s && vs_fall_c >= 0 && vs_rise_c < 0) begin
        vs_rise_c = c; vs_rise_col = int'(col_s); vs_rise_lin = int'(lin_s);
      end
      if (lin_s >= 10'd6 && aa_s) aa_bad++;
      prev_vs = vs_s;
    end
    check({tag, " fim pulses missing"}, 32'(exp_q.size()), 0);
    check({tag, " fim not at origin"}, 32'(fim_pos_bad), 0);
    check({tag, " vsync fall coluna"}, 32'(vs_fall_col), 0);
    check({tag, " vsync fall linha"},  32'(vs_fall_lin), 7);
    check({tag, " vsync rise coluna"}, 32'(vs_rise_col), 0);
    check({tag, " vsync rise linha"},  32'(vs_rise_lin), 9);
    check({tag, " vsync low clks"},    32'(vs_rise_c - vs_fall_c), 96);
    check({tag, " area in vblank"},    32'(aa_bad), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   hs_fall_col, hs_rise_col, hs_low, aa_fall_col, wrap_lin, wrap_prev_lin, aa_bad;
    int   wrapped, prev_col, prev_lin;
    logic prev_hs, prev_aa;
    int   found, pt_zero, no_adv, hs1_low, back_c;

    // Reset held for 3 clks
    rst = 1'b1;
    repeat (3) tick();
    check_reset_a("reset");
    check("reset 1 tick", 32'(pt_1), 1);
    check("reset 1 coluna", 32'(col_1), 0);
    check("reset 1 linha", 32'(lin_1), 0);
    check("reset 1 flags", {28'd0, aa_1, hs_1, vs_1, fim_1}, 32'b1110);

    rst = 1'b0;
    tick();
    check("release a coluna clk1", 32'(col_a), 0);
    check("release a tick clk1", 32'(pt_a), 1);
    tick();
    check("release a coluna clk2", 32'(col_a), 1);
    check("release a tick clk2", 32'(pt_a), 0);

    // One full line on the DIVISOR=2 instance
    hs_fall_col = -1; hs_rise_col = -1; hs_low = 0; aa_fall_col = -1;
    wrap_lin = -1; wrap_prev_lin = -1; wrapped = 0; aa_bad = 0;
    prev_hs = hs_a; prev_aa = aa_a; prev_col = int'(col_a); prev_lin = int'(lin_a);
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (prev_col == 799 && col_a == 10'd0) begin
        wrapped = 1; wrap_lin = int'(lin_a); wrap_prev_lin = prev_lin;
        break;
      end
      if (prev_hs && !hs_a) hs_fall_col = int'(col_a);
      if (!prev_hs && hs_a) hs_rise_col = int'(col_a);
      if (!hs_a) hs_low++;
      if (prev_aa && !aa_a) aa_fall_col = int'(col_a);
      if (aa_a != ((col_a < 10'd640) && (lin_a < 10'd480))) aa_bad++;
      prev_hs = hs_a; prev_aa = aa_a; prev_col = int'(col_a); prev_lin = int'(lin_a);
    end
    check("line wrapped", 32'(wrapped), 1);
    check("hsync fall coluna", 32'(hs_fall_col), 656);
    check("hsync rise coluna", 32'(hs_rise_col), 752);
    check("hsync low clks", 32'(hs_low), 192);
    check("area fall coluna", 32'(aa_fall_col), 640);
    check("area vs position", 32'(aa_bad), 0);
    check("linha before wrap", 32'(wrap_prev_lin), 0);
    check("linha after wrap", 32'(wrap_lin), 1);

    // DIVISOR=1: align on coluna 0, then watch one line
    found = 0;
    for (int c = 0; c < 900; c++) begin
      tick();
      if (col_1 == 10'd0) begin
        found = 1;
        break;
      end
    end
    check("div1 found origin", 32'(found), 1);
    pt_zero = 0; no_adv = 0; hs1_low = 0; back_c = -1;
    prev_col = int'(col_1);
    for (int c = 1; c <= 800; c++) begin
      tick();
      if (!pt_1) pt_zero++;
      if (int'(col_1) != (prev_col + 1) % 800) no_adv++;
      if (!hs_1) hs1_low++;
      if (col_1 == 10'd0 && back_c < 0) back_c = c;
      prev_col = int'(col_1);
    end
    check("div1 tick low clks", 32'(pt_zero), 0);
    check("div1 non-advance", 32'(no_adv), 0);
    check("div1 hsync low clks", 32'(hs1_low), 96);
    check("div1 line period", 32'(back_c), 800);

    // Small raster: plain reset, then two frames
    rst = 1'b1;
    repeat (2) tick();
    check_reset_s("frame reset");
    rst = 1'b0;
    small_run("frame");

    // Mid-frame reset at coluna=10, linha=4
    found = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (col_s == 10'd10 && lin_s == 10'd4) begin
        found = 1;
        break;
      end
    end
    check("mid reached position", 32'(found), 1);
    rst = 1'b1;
    tick();
    check_reset_s("mid reset");
    check_reset_a("mid reset");
    rst = 1'b0;
    small_run("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
